sensor_sequencer: RTL and testbench
===================================

Name: sensor_sequencer

Overview:
- Executes the timed hardware side of the SET_SIGNAL and AUTO_READ commands for the radiation sensor PICC.
- Drives the sensor and ADC control signals, waits out the sync period, and times timing1/timing2.
- Waits for ADC conversion, caches the result, and maintains the status flags returned in every reply.
- Sits between the app-level command decoder (upstream) and the sensor/ADC analog interface (downstream).

Parameters:
- CNT_W, 25, width of the timing down-counter; timing1/timing2 use 25 bits, sync is zero-extended.

Ports:
- clk  in  1  system clock; stops during PCD pauses on silicon.
- rst  in  1  asynchronous, active-high reset.
- start_set_signal  in  1  one-cycle pulse: SET_SIGNAL command decoded.
- start_auto_read  in  1  one-cycle pulse: AUTO_READ command decoded.
- abort  in  1  one-cycle pulse: ABORT command decoded.
- sync  in  16  sync period in clk cycles, sampled with a start pulse.
- sig_mask  in  8  Signals-format mask for SET_SIGNAL, sampled with the start pulse.
- sig_value  in  8  Signals-format value for SET_SIGNAL, sampled with the start pulse.
- timing1  in  25  AUTO_READ timing1 in clk cycles.
- timing2  in  25  AUTO_READ timing2 in clk cycles.
- pause  in  1  synchronised PCD pause indicator.
- adc_conversion_complete  in  1  level from the ADC.
- adc_value  in  16  ADC output.
- sens_config  out  3  sensor configuration.
- sens_enable  out  1  sensor enable.
- sens_read  out  1  sensor read.
- adc_enable  out  1  ADC enable.
- adc_read  out  1  ADC read.
- busy  out  1  high when state is not IDLE.
- adc_value_cached  out  16  result latched at conversion.
- flags  out  8  StatusFlags: {conv_complete, already_busy, unexpected_pause, error, 4'b0}.

Behaviour:
- Reset: state=IDLE; all sensor/ADC outputs, busy, flags and adc_value_cached = 0.
- States: IDLE, SYNC, T1, T2, ADC_WAIT.
- Start acceptance:
  - A start pulse in IDLE is accepted only if exactly one of start_set_signal/start_auto_read is high and abort is low.
  - Acceptance clears conv_complete, already_busy, unexpected_pause and error.
  - Acceptance latches the arguments and loads cnt=sync.
  - The next state is SYNC.
- SYNC:
  - Each edge: if cnt==0, apply the action; else cnt--.
  - The action therefore lands on edge E0+sync+1, where E0 is the edge that accepted the start.
  - Pause is ignored in SYNC.
- SET_SIGNAL action:
  - Internal Signals register S = (S & ~mask) | (value & mask); the padding bit is ignored.
  - If the new adc_read==1 and the old adc_read==0, go to ADC_WAIT; else go to IDLE.
- AUTO_READ:
  - Precondition at acceptance: sens_enable, sens_read, adc_enable and adc_read are all 0.
  - If the precondition fails: set error, stay IDLE, leave outputs unchanged.
  - SYNC action: sens_enable=1, cnt=timing1, go to T1.
  - T1 at cnt==0: sens_read=1, adc_enable=1, cnt=timing2, go to T2.
  - T2 at cnt==0: adc_read=1, go to ADC_WAIT.
  - sens_config is untouched by AUTO_READ.
- ADC_WAIT:
  - On adc_conversion_complete=1: adc_value_cached<=adc_value and conv_complete<=1 on the same edge.
  - If the command was AUTO_READ, also clear sens_enable, sens_read, adc_enable and adc_read.
  - Next state is IDLE in both cases.
- Pause outside SYNC: pause=1 in any cycle of T1, T2 or ADC_WAIT sets unexpected_pause (sticky). The sequence continues.
- Start while busy: either start pulse outside IDLE sets already_busy. The new command is dropped and the current operation continues unchanged.
- Simultaneous start_set_signal and start_auto_read in IDLE: set error, start nothing.
- Abort, valid in any state:
  - Next edge: state=IDLE, all five sensor/ADC outputs=0, all flags=0.
  - adc_value_cached is kept.
  - Abort wins over any simultaneous start or conversion.
- Flags are sticky until an accepted start or an abort.
- Counters saturate at 0 and never wrap. Timing values of 0 give a 1-cycle state.
- rst asserted mid-operation forces the reset values immediately (asynchronous).

Test Plan:
- SET_SIGNAL, sync=3, mask=8'hE0, value=8'hA0 -> sens_config=3'b101 exactly 4 edges after the pulse; busy drops on that edge; flags=8'h00.
- AUTO_READ, sync=2, timing1=10, timing2=5; ADC completes 7 cycles after adc_read with adc_value=16'h1234:
  - sens_enable rises at E0+3; sens_read/adc_enable rise at E0+14; adc_read rises at E0+20.
  - adc_value_cached=16'h1234, flags=8'h80, all four signals return to 0.
- AUTO_READ issued while sens_enable=1 (set by a prior SET_SIGNAL) -> flags=8'h10, state stays IDLE, outputs unchanged.
- Second start pulse during T1 -> already_busy=1 (flags=8'h40); the original timing still completes and flags end at 8'hC0.
- Pause pulses during SYNC -> no flag; one pause cycle during T2 -> unexpected_pause=1, flags=8'hA0 after conversion.
- Abort during ADC_WAIT (and abort coincident with a start) -> IDLE next edge, outputs 0, flags 8'h00, previous adc_value_cached retained.

Source files
------------

// File: rtl/sensor_sequencer.sv
// Timed sensor/ADC sequencing for SET_SIGNAL and AUTO_READ: sync wait, timing1/timing2, ADC wait.
// Status flags stay set until an accepted start or an abort; abort overrides everything except reset.
module sensor_sequencer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_set_signal,
  input  logic             start_auto_read,
  input  logic             abort,
  input  logic [15:0]      sync,
  input  logic [7:0]       sig_mask,
  input  logic [7:0]       sig_value,
  input  logic [CNT_W-1:0] timing1,
  input  logic [CNT_W-1:0] timing2,
  input  logic             pause,
  input  logic             adc_conversion_complete,
  input  logic [15:0]      adc_value,
  output logic [2:0]       sens_config,
  output logic             sens_enable,
  output logic             sens_read,
  output logic             adc_enable,
  output logic             adc_read,
  output logic             busy,
  output logic [15:0]      adc_value_cached,
  output logic [7:0]       flags
);
  typedef enum logic [2:0] {IDLE, SYNC, T1, T2, ADC_WAIT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, t1_q, t2_q;
  logic             auto_q;
  logic [7:1]       mask_q, value_q;
  logic [7:1]       sig_q;  // {sens_config, sens_enable, sens_read, adc_enable, adc_read}
  logic [15:0]      cached_q;
  logic             conv_q, abusy_q, upause_q, err_q;
  logic [7:1]       sig_d;
  logic             start_any, start_one, unused_pad;

  assign sig_d      = (sig_q & ~mask_q) | (value_q & mask_q);
  assign start_any  = start_set_signal | start_auto_read;
  assign start_one  = start_set_signal ^ start_auto_read;
  assign unused_pad = sig_mask[0] ^ sig_value[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      auto_q   <= 1'b0;
      mask_q   <= '0;
      value_q  <= '0;
      sig_q    <= '0;
      cached_q <= '0;
      conv_q   <= 1'b0;
      abusy_q  <= 1'b0;
      upause_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (abort) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      conv_q   <= 1'b0;
      abusy_q  <= 1'b0;
      upause_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q != IDLE && start_any)
        abusy_q <= 1'b1;
      if ((state_q == T1 || state_q == T2 || state_q == ADC_WAIT) && pause)
        upause_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_one) begin
            // AUTO_READ needs all four control signals low before it may own them
            if (start_auto_read && sig_q[4:1] != 4'b0000) begin
              err_q <= 1'b1;
            end else begin
              conv_q   <= 1'b0;
              abusy_q  <= 1'b0;
              upause_q <= 1'b0;
              err_q    <= 1'b0;
              auto_q   <= start_auto_read;
              mask_q   <= sig_mask[7:1];
              value_q  <= sig_value[7:1];
              t1_q     <= timing1;
              t2_q     <= timing2;
              cnt_q    <= {{(CNT_W-16){1'b0}}, sync};
              state_q  <= SYNC;
            end
          end else if (start_set_signal && start_auto_read) begin
            err_q <= 1'b1;
          end
        end
        SYNC: begin
          if (cnt_q == '0) begin
            if (auto_q) begin
              sig_q[4] <= 1'b1;
              cnt_q    <= t1_q;
              state_q  <= T1;
            end else begin
              sig_q   <= sig_d;
              state_q <= (sig_d[1] && !sig_q[1]) ? ADC_WAIT : IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        T1: begin
          if (cnt_q == '0) begin
            sig_q[3] <= 1'b1;
            sig_q[2] <= 1'b1;
            cnt_q    <= t2_q;
            state_q  <= T2;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        T2: begin
          if (cnt_q == '0) begin
            sig_q[1] <= 1'b1;
            state_q  <= ADC_WAIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ADC_WAIT: begin
          if (adc_conversion_complete) begin
            cached_q <= adc_value;
            conv_q   <= 1'b1;
            if (auto_q)
              sig_q[4:1] <= 4'b0000;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sens_config      = sig_q[7:5];
  assign sens_enable      = sig_q[4];
  assign sens_read        = sig_q[3];
  assign adc_enable       = sig_q[2];
  assign adc_read         = sig_q[1];
  assign busy             = (state_q != IDLE);
  assign adc_value_cached = cached_q;
  assign flags            = {conv_q, abusy_q, upause_q, err_q, 4'b0000};
endmodule

// File: tb/tb_sensor_sequencer.sv
// Bench for sensor_sequencer: a timeline model predicts every output after every edge into a queue;
// a monitor on the falling edge pops each prediction and compares it with the DUT.
module tb_sensor_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_set_signal, start_auto_read, abort, pause, adc_conversion_complete;
  logic [15:0] sync, adc_value;
  logic [7:0]  sig_mask, sig_value;
  logic [24:0] timing1, timing2;
  logic [2:0]  sens_config;
  logic        sens_enable, sens_read, adc_enable, adc_read, busy;
  logic [15:0] adc_value_cached;
  logic [7:0]  flags;

  typedef struct {
    int          cyc;
    logic [2:0]  cfg;
    logic [3:0]  ctl;
    logic        busy;
    logic [7:0]  flags;
    logic [15:0] cached;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [2:0]  m_cfg;
  logic [3:0]  m_ctl;  // {sens_enable, sens_read, adc_enable, adc_read}
  logic [7:0]  m_flags;
  logic [15:0] m_cached;

  sensor_sequencer #(.CNT_W(25)) dut (
    .clk(clk), .rst(rst),
    .start_set_signal(start_set_signal), .start_auto_read(start_auto_read), .abort(abort),
    .sync(sync), .sig_mask(sig_mask), .sig_value(sig_value),
    .timing1(timing1), .timing2(timing2), .pause(pause),
    .adc_conversion_complete(adc_conversion_complete), .adc_value(adc_value),
    .sens_config(sens_config), .sens_enable(sens_enable), .sens_read(sens_read),
    .adc_enable(adc_enable), .adc_read(adc_read), .busy(busy),
    .adc_value_cached(adc_value_cached), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("sens_config", 32'(sens_config), 32'(e.cfg));
        chk("ctl_signals", 32'({sens_enable, sens_read, adc_enable, adc_read}), 32'(e.ctl));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("flags", 32'(flags), 32'(e.flags));
        chk("adc_value_cached", 32'(adc_value_cached), 32'(e.cached));
      end
    end
  end

  task automatic push(input int e, input logic b);
    exp_t x;
    x.cyc = e; x.cfg = m_cfg; x.ctl = m_ctl; x.busy = b; x.flags = m_flags; x.cached = m_cached;
    sb.push_back(x);
  endtask

  task automatic idle_in();
    start_set_signal = 1'b0;
    start_auto_read  = 1'b0;
    abort            = 1'b0;
    pause            = 1'b0;
    adc_conversion_complete = 1'b0;
    adc_value        = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_in();
      pause = 1'($urandom_range(0, 1));
      adc_conversion_complete = 1'($urandom_range(0, 1));
      push(cyc + 1, 1'b0);
    end
  endtask

  // kind: 0 SET_SIGNAL, 1 AUTO_READ, 2 both starts, 3 abort alone. *_k are edge offsets from the start edge (-1 = never).
  task automatic op(input int kind, input int sy, input logic [7:0] mk, input logic [7:0] vl,
                    input int t1, input int t2, input int d, input logic [15:0] av,
                    input int xs_k, input int p1_k, input int p2_k, input int ab_k);
    logic [6:0] nsig;
    bit adcw, acc;
    int act_k, k_rd, k_ar, kc, wait_lo;
    @(negedge clk);
    idle_in();
    start_set_signal = (kind == 0 || kind == 2);
    start_auto_read  = (kind == 1 || kind == 2);
    abort     = (kind == 3 || ab_k == 0);
    sync      = 16'(sy);
    sig_mask  = mk;
    sig_value = vl;
    timing1   = 25'(t1);
    timing2   = 25'(t2);
    pause     = (p1_k == 0 || p2_k == 0);
    acc = 1'b0;
    if (abort) begin
      m_cfg = '0; m_ctl = '0; m_flags = '0;
    end else if (kind == 2 || (kind == 1 && m_ctl != 4'b0000)) begin
      m_flags |= 8'h10;
    end else begin
      acc = 1'b1;
      m_flags = '0;
    end
    push(cyc + 1, acc);
    if (!acc) return;

    nsig  = ({m_cfg, m_ctl} & ~mk[7:1]) | (vl[7:1] & mk[7:1]);
    adcw  = (kind == 0) && nsig[0] && !m_ctl[0];
    act_k = sy + 1;
    k_rd  = sy + t1 + 2;
    k_ar  = sy + t1 + t2 + 3;
    wait_lo = (kind == 1) ? k_ar + 1 : act_k + 1;
    kc    = (kind == 1) ? k_ar + d : (adcw ? act_k + d : act_k);

    for (int k = 1; k <= kc; k++) begin
      @(negedge clk);
      idle_in();
      abort            = (k == ab_k);
      start_set_signal = (k == xs_k) && k[0];
      start_auto_read  = (k == xs_k) && !k[0];
      if (k == xs_k) begin
        sync = 16'($urandom_range(0, 3));
        sig_mask = 8'($urandom);
        sig_value = 8'($urandom);
      end
      pause = (k == p1_k) || (k == p2_k);
      if (k == kc && (kind == 1 || adcw)) begin
        adc_conversion_complete = 1'b1;
        adc_value = av;
      end else if (k < wait_lo) begin
        adc_conversion_complete = 1'($urandom_range(0, 1));
      end

      if (abort) begin
        m_cfg = '0; m_ctl = '0; m_flags = '0;
        push(cyc + 1, 1'b0);
        return;
      end
      if (k == xs_k) m_flags |= 8'h40;
      if (pause && k >= sy + 2) m_flags |= 8'h20;
      if (kind == 0) begin
        if (k == act_k) {m_cfg, m_ctl} = nsig;
        if (k == kc && adcw) begin m_cached = av; m_flags |= 8'h80; end
      end else begin
        if (k == act_k) m_ctl[3] = 1'b1;
        if (k == k_rd) begin m_ctl[2] = 1'b1; m_ctl[1] = 1'b1; end
        if (k == k_ar) m_ctl[0] = 1'b1;
        if (k == kc) begin m_cached = av; m_flags |= 8'h80; m_ctl = '0; end
      end
      push(cyc + 1, k < kc);
    end
  endtask

  task automatic rand_op();
    int r    = int'($urandom_range(0, 99));
    int kind = (r < 42) ? 0 : (r < 84) ? 1 : (r < 92) ? 2 : 3;
    int ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1;
    int xs   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : -1;
    op(kind, int'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
       16'($urandom), xs, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)), ab);
    idle_cycles(int'($urandom_range(0, 3)));
  endtask

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stimulus
    rst = 1'b1;
    idle_in();
    sync = '0; sig_mask = '0; sig_value = '0; timing1 = '0; timing2 = '0;
    m_cfg = '0; m_ctl = '0; m_flags = '0; m_cached = '0;
    repeat (2) @(negedge clk);
    chk("reset_config", 32'(sens_config), 32'd0);
    chk("reset_ctl", 32'({sens_enable, sens_read, adc_enable, adc_read}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_cached", 32'(adc_value_cached), 32'd0);
    rst = 1'b0;

    op(0, 3, 8'hE0, 8'hA0, 0, 0, 1, 16'h0000, -1, -1, -1, -1);   // config 101 on E0+4
    idle_cycles(2);
    op(1, 2, 8'h00, 8'h00, 10, 5, 7, 16'h1234, -1, -1, -1, -1);  // full AUTO_READ, flags 80
    idle_cycles(2);
    op(0, 0, 8'h10, 8'h10, 0, 0, 1, 16'h0000, -1, -1, -1, -1);   // sens_enable = 1
    op(1, 1, 8'h00, 8'h00, 3, 3, 2, 16'h0000, -1, -1, -1, -1);   // rejected: flags 10
    idle_cycles(1);
    op(0, 1, 8'h10, 8'h00, 0, 0, 1, 16'h0000, -1, -1, -1, -1);   // sens_enable = 0
    op(1, 1, 8'h00, 8'h00, 4, 2, 2, 16'hBEEF, 4, -1, -1, -1);    // second start in T1: C0
    idle_cycles(1);
    op(1, 3, 8'h00, 8'h00, 2, 3, 3, 16'h5A5A, -1, 2, 8, -1);     // pause in SYNC and T2: A0
    idle_cycles(1);
    op(1, 1, 8'h00, 8'h00, 1, 1, 4, 16'hFFFF, -1, -1, -1, 8);    // abort in ADC_WAIT
    op(1, 1, 8'h00, 8'h00, 1, 1, 2, 16'h0000, -1, -1, -1, 0);    // abort with start
    op(2, 1, 8'hFF, 8'hFF, 1, 1, 1, 16'h0000, -1, -1, -1, -1);   // both starts: error
    op(3, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, -1, -1, -1, -1);   // abort alone
    idle_cycles(2);

    for (int n = 0; n < 60; n++) rand_op();
    idle_cycles(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    start_set_signal = 1'b1; sync = 16'd6; sig_mask = 8'hFE; sig_value = 8'hFE;
    @(negedge clk);
    start_set_signal = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_before_async_rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_flags", 32'(flags), 32'd0);
    chk("async_rst_cached", 32'(adc_value_cached), 32'd0);
    chk("async_rst_outputs", 32'({sens_config, sens_enable, sens_read, adc_enable, adc_read}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
